ddr2_sys_master_0_p2b_converter: RTL and testbench

- Packets-to-bytes converter: serialises an Avalon-ST packet stream (data, channel, SOP, EOP) into a flat 8-bit byte stream for the host/JTAG byte link.
- Framing is carried in-band with special characters: SOP 0x7A, EOP 0x7B, CHANNEL 0x7C, ESCAPE 0x7D.
- Sits on the master return path. It is the transmit-side counterpart of the bytes-to-packets path, which decodes these characters.

---
 rtl/ddr2_sys_master_0_p2b_converter.sv | 127 ++++++++++++
 tb/tb_ddr2_sys_master_0_p2b_converter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_sys_master_0_p2b_converter.sv
// Packets-to-bytes converter: serialises Avalon-ST beats into an escaped byte stream
// with in-band SOP/EOP/CHANNEL framing characters; one registered output byte.
module ddr2_sys_master_0_p2b_converter #(
   parameter int CHANNEL_WIDTH  = 8,
   parameter bit ENCODE_CHANNEL = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     in_ready,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic [CHANNEL_WIDTH-1:0] in_channel,
   input  logic                     in_startofpacket,
   input  logic                     in_endofpacket,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [7:0]               out_data
);

   localparam logic [7:0] SOP_CHAR = 8'h7A;
   localparam logic [7:0] EOP_CHAR = 8'h7B;
   localparam logic [7:0] CHN_CHAR = 8'h7C;
   localparam logic [7:0] ESC_CHAR = 8'h7D;

   // State names the step last completed for the current beat (HDR = none yet).
   typedef enum logic [2:0] {HDR, CHAN_VAL, CHAN_ESC, SOP_CH, EOP_CH, DATA_ESC} state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic                     r_out_valid;
   logic [7:0]               r_out_data;
   logic                     r_chan_known;
   logic [CHANNEL_WIDTH-1:0] r_last_chan;

   logic                     w_load;
   logic                     w_need_hdr;
   logic [7:0]               w_chan8;
   logic [7:0]               w_byte;
   logic                     w_final;
   logic                     w_chan_done;
   logic [7:0]               w_dat_byte;
   state_t                   w_dat_nxt;
   logic                     w_dat_final;

   function automatic logic is_special(input logic [7:0] b);
      return (b >= SOP_CHAR) && (b <= ESC_CHAR);
   endfunction

   assign w_load     = !r_out_valid || out_ready;
   assign w_chan8    = 8'(in_channel);
   assign w_need_hdr = ENCODE_CHANNEL && (!r_chan_known || (in_channel != r_last_chan));

   // Data step, shared by every state from which the payload byte can follow.
   assign w_dat_byte  = is_special(in_data) ? ESC_CHAR : in_data;
   assign w_dat_nxt   = is_special(in_data) ? DATA_ESC : HDR;
   assign w_dat_final = !is_special(in_data);

   always_comb begin
      w_byte      = 8'h00;
      w_state_nxt = r_state;
      w_final     = 1'b0;
      w_chan_done = 1'b0;
      case (r_state)
         HDR: begin
            if (w_need_hdr) begin
               w_byte = CHN_CHAR; w_state_nxt = CHAN_VAL;
            end else if (in_startofpacket) begin
               w_byte = SOP_CHAR; w_state_nxt = SOP_CH;
            end else if (in_endofpacket) begin
               w_byte = EOP_CHAR; w_state_nxt = EOP_CH;
            end else begin
               w_byte = w_dat_byte; w_state_nxt = w_dat_nxt; w_final = w_dat_final;
            end
         end
         CHAN_VAL: begin
            if (is_special(w_chan8)) begin
               w_byte = ESC_CHAR; w_state_nxt = CHAN_ESC;
            end else begin
               // Channel recorded now so HDR resumes with SOP/EOP/data only.
               w_byte = w_chan8; w_state_nxt = HDR; w_chan_done = 1'b1;
            end
         end
         CHAN_ESC: begin
            w_byte = w_chan8 ^ 8'h20; w_state_nxt = HDR; w_chan_done = 1'b1;
         end
         SOP_CH: begin
            if (in_endofpacket) begin
               w_byte = EOP_CHAR; w_state_nxt = EOP_CH;
            end else begin
               w_byte = w_dat_byte; w_state_nxt = w_dat_nxt; w_final = w_dat_final;
            end
         end
         EOP_CH: begin
            w_byte = w_dat_byte; w_state_nxt = w_dat_nxt; w_final = w_dat_final;
         end
         DATA_ESC: begin
            w_byte = in_data ^ 8'h20; w_state_nxt = HDR; w_final = 1'b1;
         end
         default: w_state_nxt = HDR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= HDR;
         r_out_valid  <= 1'b0;
         r_out_data   <= 8'h00;
         r_chan_known <= 1'b0;
         r_last_chan  <= '0;
      end else if (w_load) begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_data <= w_byte;
            r_state    <= w_state_nxt;
            if (w_chan_done || w_final) begin
               r_chan_known <= 1'b1;
               r_last_chan  <= in_channel;
            end
         end
      end
   end

   assign in_ready  = in_valid && w_load && w_final;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_ddr2_sys_master_0_p2b_converter.sv
// Bench for the packets-to-bytes converter: directed and random beats scored against
// an expected byte queue built from the framing rules; two instances (channel encode on/off).
module tb_ddr2_sys_master_0_p2b_converter;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic [CW-1:0] in_channel = '0;
   logic          in_sop = 1'b0;
   logic          in_eop = 1'b0;
   logic          out_ready = 1'b1;
   logic          sel = 1'b0;
   logic          rdy0, rdy1, ov0, ov1;
   logic [7:0]    od0, od1;
   logic          in_ready, out_valid;
   logic [7:0]    out_data;

   ddr2_sys_master_0_p2b_converter #(.CHANNEL_WIDTH(CW), .ENCODE_CHANNEL(1'b1)) u_dut_enc (
      .clk(clk), .reset(reset), .in_ready(rdy0), .in_valid(in_valid), .in_data(in_data),
      .in_channel(in_channel), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
      .out_ready(out_ready), .out_valid(ov0), .out_data(od0));

   ddr2_sys_master_0_p2b_converter #(.CHANNEL_WIDTH(CW), .ENCODE_CHANNEL(1'b0)) u_dut_noenc (
      .clk(clk), .reset(reset), .in_ready(rdy1), .in_valid(in_valid), .in_data(in_data),
      .in_channel(in_channel), .in_startofpacket(in_sop), .in_endofpacket(in_eop),
      .out_ready(out_ready), .out_valid(ov1), .out_data(od1));

   assign in_ready  = sel ? rdy1 : rdy0;
   assign out_valid = sel ? ov1 : ov0;
   assign out_data  = sel ? od1 : od0;

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model: expected output bytes, plus the channel history it depends on.
   logic [7:0] exp_q[$];
   bit         m_known = 1'b0;
   logic [7:0] m_last = 8'h00;

   task automatic push_esc(input logic [7:0] b);
      if (b == 8'h7A || b == 8'h7B || b == 8'h7C || b == 8'h7D) begin
         exp_q.push_back(8'h7D);
         exp_q.push_back(b ^ 8'h20);
      end else begin
         exp_q.push_back(b);
      end
   endtask

   task automatic model_beat(input logic [7:0] ch, input logic [7:0] d, input bit sop, input bit eop);
      if (!sel && (!m_known || ch != m_last)) begin
         exp_q.push_back(8'h7C);
         push_esc(ch);
      end
      if (sop) exp_q.push_back(8'h7A);
      if (eop) exp_q.push_back(8'h7B);
      push_esc(d);
      m_known = 1'b1;
      m_last  = ch;
   endtask

   // out_ready: 0 = always 1, 1 = random, 2 = repeating 1,0,0
   int rdy_mode = 0;
   int rdy_cnt  = 0;
   always @(posedge clk) begin
      #1;
      rdy_cnt++;
      case (rdy_mode)
         1:       out_ready = 1'($urandom_range(0, 1));
         2:       out_ready = (rdy_cnt % 3 == 0);
         default: out_ready = 1'b1;
      endcase
   end

   // Output monitor / scoreboard
   bit         prev_stall = 1'b0;
   logic [7:0] prev_dat = 8'h00;
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (!in_valid) chk("rdy_without_vld", in_ready, 1'b0);
         if (out_valid) begin
            if (prev_stall) chk("hold_under_bp", out_data, prev_dat);
            if (out_ready) begin
               chk("byte_expected", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) chk("out_byte", out_data, exp_q.pop_front());
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_dat   = out_data;
      end
   end

   task automatic send_beat(input logic [7:0] ch, input logic [7:0] d, input bit sop, input bit eop,
                            output int cyc);
      bit done = 1'b0;
      model_beat(ch, d, sop, eop);
      in_channel = ch; in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
      cyc = 0;
      while (!done && cyc < 64) begin
         @(negedge clk);
         cyc++;
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("beat_consumed", done, 1'b1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      chk("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      m_known = 1'b0;
      m_last  = 8'h00;
      @(posedge clk);
      #1;
   endtask

   logic [7:0] chs[6] = '{8'h00, 8'h01, 8'h03, 8'h7A, 8'h7B, 8'h7D};

   task automatic random_beats(input int n);
      int         cyc;
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = ($urandom_range(0, 2) == 0) ? 8'(8'h7A + $urandom_range(0, 3)) : 8'($urandom);
         send_beat(chs[$urandom_range(0, 5)], d, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), cyc);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int cyc;
      do_reset();

      // Single-beat packet: header, SOP, EOP, data; consumed on the fifth cycle
      send_beat(8'h00, 8'h11, 1'b1, 1'b1, cyc);
      chk("first_beat_cycles", cyc, 5);
      drain();

      // Same channel: no header
      send_beat(8'h00, 8'h01, 1'b1, 1'b0, cyc);
      send_beat(8'h00, 8'h02, 1'b0, 1'b0, cyc);
      send_beat(8'h00, 8'h03, 1'b0, 1'b1, cyc);
      chk("plain_data_cycles", cyc, 2);
      drain();

      // Escapes in data and channel value
      send_beat(8'h00, 8'h7D, 1'b0, 1'b0, cyc);
      send_beat(8'h7B, 8'h7A, 1'b1, 1'b0, cyc);
      drain();

      // Channel switch 0 -> 3 -> 3
      send_beat(8'h00, 8'h40, 1'b1, 1'b0, cyc);
      send_beat(8'h03, 8'h41, 1'b0, 1'b0, cyc);
      send_beat(8'h03, 8'h42, 1'b0, 1'b1, cyc);
      drain();

      // Backpressure with the single-beat packet
      do_reset();
      rdy_mode = 2;
      send_beat(8'h00, 8'h11, 1'b1, 1'b1, cyc);
      drain();
      rdy_mode = 0;

      // Reset between the two bytes of an escape pair
      send_beat(8'h03, 8'h05, 1'b0, 1'b0, cyc);
      drain();
      model_beat(8'h03, 8'h7D, 1'b0, 1'b0);
      in_channel = 8'h03; in_data = 8'h7D; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("esc_first_byte", out_data, 8'h7D);
      do_reset();
      send_beat(8'h00, 8'h22, 1'b1, 1'b1, cyc);
      drain();

      // Random traffic with random backpressure
      rdy_mode = 1;
      random_beats(150);
      drain();

      // Channel encoding disabled
      sel = 1'b1;
      do_reset();
      random_beats(60);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
